// File: rtl/revo_marker_generator_pkg.sv
// Shared definitions for the revolution marker generator: lock FSM encoding,
// SuperKEKB ring constants and the word-alignment priority encoder.
package revo_marker_generator_pkg;

  // Lock tracking states.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // SuperKEKB ring: quad bunches per revolution and bunch sub-slots per word.
  localparam int SKB_QUAD_BUNCHES = 1280;
  localparam int SKB_SUBSLOTS     = 8;

  // Index of the first set bit counting from the MSB (bit 7 -> 0, bit 0 -> 7).
  function automatic logic [2:0] first_set_from_msb(input logic [SKB_SUBSLOTS-1:0] word);
    logic [2:0] idx;
    idx = 3'd0;
    // Walk from the latest slot toward the earliest so the earliest set bit wins.
    for (int i = SKB_SUBSLOTS - 1; i >= 0; i--) begin
      if (word[SKB_SUBSLOTS-1-i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/revo_marker_generator_edge_detector.sv
// Detects the rising edge of the revolution word (previous word all-zero,
// current word non-zero) and reports where inside the word the edge sits.
module revo_edge_detector
  import revo_marker_generator_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SKB_SUBSLOTS-1:0] revo_word_i,
  output logic                    edge_flag_o,
  output logic [2:0]              align_o
);

  logic [SKB_SUBSLOTS-1:0] prev_word_q;

  // Previous word register; preset to all-ones so the first word after reset
  // can never look like an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_word_q <= '1;
    end else begin
      prev_word_q <= revo_word_i;
    end
  end

  assign edge_flag_o = (prev_word_q == '0) && (revo_word_i != '0);
  assign align_o     = first_set_from_msb(revo_word_i);

endmodule

// File: rtl/revo_marker_generator.sv
// Locks to the per-clock revolution word, tracks the bunch phase within the
// revolution and emits a one-hot bunch marker at the selected position.
module revo_marker_generator
  import revo_marker_generator_pkg::*;
#(
  parameter int REVOLUTION_LENGTH = SKB_QUAD_BUNCHES,
  parameter int LOCK_COUNT        = 4,
  parameter int PHASE_WIDTH       = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  revo_word,
  input  logic        enable,
  input  logic [13:0] bunch_select,
  output logic [7:0]  marker_word,
  output logic        locked,
  output logic [15:0] revolution_count,
  output logic [7:0]  lock_loss_count
);

  localparam logic [PHASE_WIDTH-1:0] PHASE_SAT  = PHASE_WIDTH'(REVOLUTION_LENGTH);
  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(REVOLUTION_LENGTH - 1);
  localparam int                     GOOD_W     = $clog2(LOCK_COUNT) + 1;
  localparam logic [GOOD_W-1:0]      GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);

  logic                   edge_flag;
  logic [2:0]             align;
  lock_state_e            state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [2:0]             align_q, align_d;
  logic [15:0]            rev_cnt_q, rev_cnt_d;
  logic [7:0]             loss_q, loss_d;
  logic [7:0]             marker_q, marker_d;
  logic                   good_edge;
  logic                   timeout;
  logic [10:0]            sel_phase;
  logic                   sel_hit;

  revo_edge_detector u_edge (
    .clock       (clock),
    .reset       (reset),
    .revo_word_i (revo_word),
    .edge_flag_o (edge_flag),
    .align_o     (align)
  );

  // A period is good when the edge lands exactly one revolution after the last
  // one with the same intra-word alignment; timeout is the phase reaching
  // saturation without an edge.
  assign good_edge = (phase_q == PHASE_LAST) && (align == align_q);
  assign timeout   = !edge_flag && (phase_q == PHASE_LAST);

  // Phase for the current input cycle: reload on edge, otherwise count and
  // stick at the revolution length.
  always_comb begin
    phase_d = phase_q;
    if (edge_flag) begin
      phase_d = '0;
    end else if (phase_q != PHASE_SAT) begin
      phase_d = phase_q + PHASE_WIDTH'(1);
    end
  end

  // Marker compare uses the reloaded phase so position 0 fires on the edge
  // cycle; selections at or beyond the revolution length never match, even
  // against the saturated phase.
  assign sel_phase = bunch_select[13:3];
  assign sel_hit   = (32'(sel_phase) < 32'(REVOLUTION_LENGTH)) &&
                     (32'(sel_phase) == 32'(phase_d));

  always_comb begin
    marker_d = 8'h00;
    if (enable && (state_q == ST_LOCKED) && sel_hit) begin
      marker_d = 8'h80 >> bunch_select[2:0];
    end
  end

  // Lock FSM next state plus the good-period, alignment and slow-control counters.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    align_d   = align_q;
    rev_cnt_d = rev_cnt_q;
    loss_d    = loss_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (edge_flag) begin
          state_d = ST_CHECKING;
          good_d  = '0;
          align_d = align;
        end
      end
      ST_CHECKING: begin
        if (edge_flag) begin
          if (good_edge) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d  = '0;
            align_d = align;
          end
        end else if (timeout) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (edge_flag && good_edge) begin
          rev_cnt_d = rev_cnt_q + 16'd1;
        end else if (edge_flag || timeout) begin
          state_d = ST_UNLOCKED;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_UNLOCKED;
      phase_q   <= PHASE_SAT;
      good_q    <= '0;
      align_q   <= 3'd0;
      rev_cnt_q <= 16'd0;
      loss_q    <= 8'd0;
      marker_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      good_q    <= good_d;
      align_q   <= align_d;
      rev_cnt_q <= rev_cnt_d;
      loss_q    <= loss_d;
      marker_q  <= marker_d;
    end
  end

  assign marker_word      = marker_q;
  assign locked           = (state_q == ST_LOCKED);
  assign revolution_count = rev_cnt_q;
  assign lock_loss_count  = loss_q;

endmodule
